// File: rtl/descriptor_output_arbiter.sv
// Merges one time-sensitive descriptor path and NTS_CH FIFO-buffered non-time-sensitive paths onto one output.
// Two cycles from request to o_descriptor_wr; output is held until i_descriptor_ack, and full NTS FIFOs drop and count.

// Generic synchronous FIFO: write ignored when full, read ignored when empty, head visible combinationally.
module fifo_sync #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         wr_vld_i,
    input  logic [W-1:0] wr_dat_i,
    input  logic         rd_rdy_i,
    output logic [W-1:0] rd_dat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_wr;
    logic          do_rd;

    // Full comes from the registered count, so a same-cycle read never makes room for a write.
    assign full_o   = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o  = (cnt_q == '0);
    assign do_wr    = wr_vld_i && !full_o;
    assign do_rd    = rd_rdy_i && !empty_o;
    assign rd_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module descriptor_output_arbiter #(
    parameter int DESC_W     = 40,
    parameter int NTS_CH     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [DESC_W-1:0]        iv_ts_descriptor,
    input  logic                     i_ts_descriptor_wr,
    output logic                     o_ts_descriptor_ack,
    input  logic [NTS_CH*DESC_W-1:0] iv_nts_descriptor,
    input  logic [NTS_CH-1:0]        iv_nts_descriptor_wr,
    output logic [NTS_CH-1:0]        ov_nts_fifo_full,
    output logic [15:0]              ov_nts_drop_cnt,
    output logic [DESC_W-1:0]        ov_descriptor,
    output logic                     o_descriptor_wr,
    input  logic                     i_descriptor_ack
);
    localparam int CH_W = (NTS_CH > 1) ? $clog2(NTS_CH) : 1;

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t              state_q;
    logic                ts_full_q;
    logic                ts_ack_q;
    logic [DESC_W-1:0]   ts_dat_q;
    logic [DESC_W-1:0]   out_dat_q;
    logic                out_wr_q;
    logic [CH_W-1:0]     last_grant_q;
    logic [15:0]         drop_cnt_q;
    logic [15:0]         drop_cnt_d;
    logic [16:0]         drop_sum;
    logic [3:0]          drops;
    logic [CH_W-1:0]     winner;
    logic [CH_W-1:0]     idx;
    logic                nts_any;
    logic                ts_capture;
    logic                ts_take;
    logic [NTS_CH-1:0]   nts_empty;
    logic [NTS_CH-1:0]   nts_pop;
    logic [DESC_W-1:0]   nts_head [NTS_CH];

    for (genvar k = 0; k < NTS_CH; k++) begin : g_nts
        fifo_sync #(.W(DESC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i    (i_clk),
            .rst_n_i  (i_rst_n),
            .wr_vld_i (iv_nts_descriptor_wr[k]),
            .wr_dat_i (iv_nts_descriptor[k*DESC_W +: DESC_W]),
            .rd_rdy_i (nts_pop[k]),
            .rd_dat_o (nts_head[k]),
            .full_o   (ov_nts_fifo_full[k]),
            .empty_o  (nts_empty[k])
        );
    end

    // Walk the ring backwards so the last hit is the channel nearest after last_grant.
    always_comb begin
        winner  = last_grant_q;
        nts_any = 1'b0;
        idx     = '0;
        for (int i = NTS_CH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(last_grant_q) + 1 + i) % NTS_CH);
            if (!nts_empty[idx]) begin
                winner  = idx;
                nts_any = 1'b1;
            end
        end
    end

    assign ts_take    = (state_q == IDLE) && ts_full_q;
    assign nts_pop    = ((state_q == IDLE) && !ts_full_q && nts_any) ? (NTS_CH'(1) << winner) : '0;
    // The ack cycle blocks capture so a still-held request is not taken twice.
    assign ts_capture = i_ts_descriptor_wr && !ts_full_q && !ts_ack_q;

    always_comb begin
        drops = '0;
        for (int k = 0; k < NTS_CH; k++) begin
            drops = drops + 4'(iv_nts_descriptor_wr[k] & ov_nts_fifo_full[k]);
        end
        drop_sum   = 17'(drop_cnt_q) + 17'(drops);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ts_full_q  <= 1'b0;
            ts_ack_q   <= 1'b0;
            ts_dat_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            ts_ack_q   <= ts_capture;
            drop_cnt_q <= drop_cnt_d;
            if (ts_capture) begin
                ts_full_q <= 1'b1;
                ts_dat_q  <= iv_ts_descriptor;
            end else if (ts_take) begin
                ts_full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            out_dat_q    <= '0;
            out_wr_q     <= 1'b0;
            last_grant_q <= CH_W'(NTS_CH - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (ts_full_q) begin
                        out_dat_q <= ts_dat_q;
                        out_wr_q  <= 1'b1;
                        state_q   <= WAIT_ACK;
                    end else if (nts_any) begin
                        out_dat_q    <= nts_head[winner];
                        out_wr_q     <= 1'b1;
                        last_grant_q <= winner;
                        state_q      <= WAIT_ACK;
                    end else begin
                        out_dat_q <= '0;
                        out_wr_q  <= 1'b0;
                    end
                end
                WAIT_ACK: begin
                    if (i_descriptor_ack) begin
                        out_dat_q <= '0;
                        out_wr_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    out_dat_q <= '0;
                    out_wr_q  <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign o_ts_descriptor_ack = ts_ack_q;
    assign ov_nts_drop_cnt     = drop_cnt_q;
    assign ov_descriptor       = out_dat_q;
    assign o_descriptor_wr     = out_wr_q;
endmodule
